// File: rtl/coprocessor_0_pkg.sv
// CP0 shared definitions: register indices, field positions,
// the eret encoding and exception codes.
package cp0_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam int SR_IE   = 0;
    localparam int SR_EXL  = 1;
    localparam int IM_LO   = 10;
    localparam int IM_HI   = 15;
    localparam int EXC_LO  = 2;
    localparam int EXC_HI  = 6;
    localparam int CAUSE_BD = 31;

    localparam logic [31:0] ERET = 32'h4200_0018;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

endpackage

// File: rtl/coprocessor_0_if.sv
// Pipeline <-> CP0 bundle; the CPU side is master, CP0 is slave.
interface coprocessor_0_if;

    logic [31:0] instr;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] din;
    logic [31:0] PC;
    logic [4:0]  ExcCode;
    logic [5:0]  HWInt;
    logic        WE;
    logic        EXLClr;
    logic        EXLSet;
    logic        IntReq;
    logic [31:0] EPC;
    logic [31:0] dout;

    modport master (
        output instr, A1, A2, din, PC, ExcCode, HWInt,
        output WE, EXLClr, EXLSet,
        input  IntReq, EPC, dout
    );

    modport slave (
        input  instr, A1, A2, din, PC, ExcCode, HWInt,
        input  WE, EXLClr, EXLSet,
        output IntReq, EPC, dout
    );

endinterface

// File: rtl/coprocessor_0.sv
// System control coprocessor: SR/Cause/EPC/PRId registers and the
// combined interrupt/exception request for the M stage.
module coprocessor_0 #(
    parameter logic [31:0] PRID         = 32'h0000_4F01,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
    input logic            clk,
    input logic            reset,
    coprocessor_0_if.slave bus
);
    import cp0_pkg::*;

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] rdata;
    logic        eret;
    logic        unused;

    // Handler address is consumed by fetch; low PC bits are word-aligned away.
    assign unused = ^{bus.PC[1:0], HANDLER_ADDR};

    assign eret = (bus.instr == ERET);

    always_comb begin
        im_d  = im_q;
        exl_d = exl_q;
        ie_d  = ie_q;
        ip_d  = bus.HWInt;
        exc_d = exc_q;
        epc_d = epc_q;
        if (bus.EXLSet) begin
            exl_d = 1'b1;
            epc_d = {bus.PC[31:2], 2'b00};
            exc_d = bus.ExcCode;
        end else begin
            if (bus.WE) begin
                case (bus.A2)
                    REG_SR: begin
                        im_d  = bus.din[IM_HI:IM_LO];
                        exl_d = bus.din[SR_EXL];
                        ie_d  = bus.din[SR_IE];
                    end
                    REG_EPC: epc_d = bus.din;
                    default: ;
                endcase
            end
            // Return clears EXL even over an mtc0 to SR.
            if (bus.EXLClr || eret) exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_q  <= '0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            ip_q  <= '0;
            exc_q <= '0;
            epc_q <= '0;
        end else begin
            im_q  <= im_d;
            exl_q <= exl_d;
            ie_q  <= ie_d;
            ip_q  <= ip_d;
            exc_q <= exc_d;
            epc_q <= epc_d;
        end
    end

    assign bus.IntReq = reset & ~exl_q &
                        ((ie_q & |(bus.HWInt & im_q)) | (|bus.ExcCode));

    always_comb begin
        rdata = '0;
        case (bus.A1)
            REG_SR: begin
                rdata[IM_HI:IM_LO] = im_q;
                rdata[SR_EXL]      = exl_q;
                rdata[SR_IE]       = ie_q;
            end
            REG_CAUSE: begin
                rdata[CAUSE_BD]      = 1'b0;
                rdata[IM_HI:IM_LO]   = ip_q;
                rdata[EXC_HI:EXC_LO] = exc_q;
            end
            REG_EPC:  rdata = epc_q;
            REG_PRID: rdata = PRID;
            default:  rdata = '0;
        endcase
    end

    assign bus.dout = rdata;
    assign bus.EPC  = epc_q;

endmodule

// File: tb/tb_coprocessor_0.sv
// Directed plus randomized bench for coprocessor_0 against a
// word-level model of the CP0 register rules.
module tb_coprocessor_0;

    localparam logic [31:0] PRID = 32'h0000_4F01;
    localparam logic [31:0] ERET_W = 32'h4200_0018;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    bit   mon_en;

    coprocessor_0_if bus();

    coprocessor_0 #(.PRID(PRID)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m_sr, m_cause, m_epc;

    function automatic logic [31:0] m_read(logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_req();
        logic [5:0] im;
        im = m_sr[15:10];
        if (!rst_n) return 1'b0;
        if (m_sr[1]) return 1'b0;
        return (m_sr[0] && ((bus.HWInt & im) != 6'd0)) ||
               (bus.ExcCode != 5'd0);
    endfunction

    function automatic logic [95:0] m_next();
        logic [31:0] sr, cause, epc;
        sr    = m_sr;
        epc   = m_epc;
        cause = (m_cause & ~32'h0000_FC00) | {16'd0, bus.HWInt, 10'd0};
        if (bus.EXLSet) begin
            sr    = sr | 32'd2;
            epc   = bus.PC & ~32'd3;
            cause = (cause & ~32'h0000_007C) | {25'd0, bus.ExcCode, 2'd0};
        end else begin
            if (bus.WE && bus.A2 == 5'd12) sr = bus.din & 32'h0000_FC03;
            if (bus.WE && bus.A2 == 5'd14) epc = bus.din;
            if (bus.EXLClr || bus.instr == ERET_W) sr = sr & ~32'd2;
        end
        return {sr, cause, epc};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sr    <= '0;
            m_cause <= '0;
            m_epc   <= '0;
        end else begin
            {m_sr, m_cause, m_epc} <= m_next();
        end
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("m_req", {31'd0, bus.IntReq}, {31'd0, m_req()});
            check("m_epc", bus.EPC, m_epc);
            check("m_dout", bus.dout, m_read(bus.A1));
        end
    end

    task automatic idle();
        bus.instr   = '0;
        bus.A1      = 5'd12;
        bus.A2      = '0;
        bus.din     = '0;
        bus.PC      = '0;
        bus.ExcCode = '0;
        bus.HWInt   = '0;
        bus.WE      = 1'b0;
        bus.EXLClr  = 1'b0;
        bus.EXLSet  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(logic [4:0] a, logic [31:0] d);
        bus.WE = 1'b1;
        bus.A2 = a;
        bus.din = d;
        tick();
        bus.WE = 1'b0;
    endtask

    task automatic rd(string tag, logic [4:0] a, logic [31:0] exp);
        bus.A1 = a;
        #1;
        check(tag, bus.dout, exp);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mon_en = 0;
        idle();
        rst_n = 1'b0;
        tick();
        mon_en = 1;
        tick();
        rd("rst_sr", 5'd12, 32'd0);
        rd("rst_cause", 5'd13, 32'd0);
        rst_n = 1'b1;

        // interrupt entry
        mtc0(5'd12, 32'h0000_0401);
        bus.HWInt = 6'b000001;
        bus.PC = 32'h0000_3008;
        #1 check("t1_req", {31'd0, bus.IntReq}, 32'd1);
        bus.EXLSet = 1'b1;
        tick();
        bus.EXLSet = 1'b0;
        check("t1_epc", bus.EPC, 32'h0000_3008);
        rd("t1_sr", 5'd12, 32'h0000_0403);
        check("t1_req0", {31'd0, bus.IntReq}, 32'd0);
        rd("t1_cause", 5'd13, 32'h0000_0400);

        // return via EXLClr, then via eret
        bus.EXLClr = 1'b1;
        tick();
        bus.EXLClr = 1'b0;
        rd("t4_sr", 5'd12, 32'h0000_0401);
        check("t4_req", {31'd0, bus.IntReq}, 32'd1);
        bus.EXLSet = 1'b1;
        tick();
        bus.EXLSet = 1'b0;
        bus.instr = ERET_W;
        tick();
        bus.instr = '0;
        rd("t4_eret_sr", 5'd12, 32'h0000_0401);
        check("t4_eret_req", {31'd0, bus.IntReq}, 32'd1);

        // masked interrupt
        bus.HWInt = '0;
        mtc0(5'd12, 32'h0000_0001);
        bus.HWInt = 6'b111111;
        #1 check("t2_req", {31'd0, bus.IntReq}, 32'd0);
        tick();
        rd("t2_cause", 5'd13, 32'h0000_FC00);

        // synchronous exception
        bus.HWInt = '0;
        mtc0(5'd12, 32'h0000_0000);
        bus.ExcCode = 5'd10;
        bus.PC = 32'h0000_3010;
        #1 check("t3_req", {31'd0, bus.IntReq}, 32'd1);
        bus.EXLSet = 1'b1;
        tick();
        bus.EXLSet = 1'b0;
        check("t3_req_exl", {31'd0, bus.IntReq}, 32'd0);
        bus.ExcCode = '0;
        rd("t3_cause", 5'd13, 32'h0000_0028);
        check("t3_epc", bus.EPC, 32'h0000_3010);

        // mtc0 / mfc0
        bus.EXLClr = 1'b1;
        tick();
        bus.EXLClr = 1'b0;
        bus.WE = 1'b1;
        bus.A2 = 5'd14;
        bus.din = 32'h0000_3abc;
        rd("t5_pre", 5'd14, 32'h0000_3010);
        tick();
        bus.WE = 1'b0;
        rd("t5_epc", 5'd14, 32'h0000_3abc);
        mtc0(5'd13, 32'hFFFF_FFFF);
        mtc0(5'd15, 32'h1234_5678);
        rd("t5_cause", 5'd13, 32'h0000_0028);
        rd("t5_prid", 5'd15, PRID);
        rd("t5_other", 5'd3, 32'd0);

        // priority: EXLSet beats mtc0
        bus.WE = 1'b1;
        bus.A2 = 5'd14;
        bus.din = 32'hDEAD_BEEF;
        bus.PC = 32'h0000_3022;
        bus.EXLSet = 1'b1;
        tick();
        bus.WE = 1'b0;
        bus.EXLSet = 1'b0;
        check("t6_epc", bus.EPC, 32'h0000_3020);

        // asynchronous reset mid-cycle
        bus.HWInt = 6'b111111;
        bus.ExcCode = 5'd4;
        #1 rst_n = 1'b0;
        #1 check("t6_rst_req", {31'd0, bus.IntReq}, 32'd0);
        check("t6_rst_epc", bus.EPC, 32'd0);
        rd("t6_rst_sr", 5'd12, 32'd0);
        rd("t6_rst_cause", 5'd13, 32'd0);
        idle();
        tick();
        rst_n = 1'b1;

        // randomized traffic, checked by the negedge monitor
        for (int i = 0; i < 400; i++) begin
            bus.A1      = 5'($urandom_range(10, 17));
            bus.A2      = ($urandom_range(0, 3) == 0) ? 5'($urandom) :
                          5'($urandom_range(12, 15));
            bus.din     = $urandom;
            bus.PC      = $urandom;
            bus.HWInt   = 6'($urandom);
            bus.WE      = ($urandom_range(0, 2) == 0);
            bus.EXLClr  = ($urandom_range(0, 7) == 0);
            bus.EXLSet  = ($urandom_range(0, 5) == 0);
            bus.instr   = ($urandom_range(0, 9) == 0) ? ERET_W : $urandom;
            bus.ExcCode = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'd0;
            tick();
        end

        idle();
        tick();
        mon_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
